seq_shift_add_multiplier: RTL

//   Parametrised sequential shift-add multiplier: N-bit x N-bit -> 2N-bit product.

---
 rtl/seq_shift_add_multiplier.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: N x N -> 2N product, signed or unsigned per operation.
// Sign is handled by multiplying magnitudes and negating the accumulator at the end.
module seq_shift_add_multiplier #(
   parameter int N          = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   A_in,
   input  logic [N-1:0]   B_in,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] result_out
);

   localparam int ITW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t         state_q;
   logic [2*N-1:0] mcand_q;
   logic [2*N-1:0] acc_q;
   logic [2*N-1:0] result_q;
   logic [N-1:0]   mplier_q;
   logic [ITW-1:0] iter_q;
   logic           neg_q;
   logic           busy_q;
   logic           done_q;

   logic [N-1:0]   aMag_d;
   logic [N-1:0]   bMag_d;
   logic           neg_d;
   logic           term_d;
   logic [2*N-1:0] accSum_d;

   // The magnitude of the most negative value still fits in N unsigned bits.
   always_comb begin
      aMag_d   = (signed_mode && A_in[N-1]) ? -A_in : A_in;
      bMag_d   = (signed_mode && B_in[N-1]) ? -B_in : B_in;
      neg_d    = signed_mode & (A_in[N-1] ^ B_in[N-1]);
      term_d   = (iter_q == ITW'(N)) || (EARLY_EXIT && (mplier_q == '0));
      accSum_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
         mplier_q <= '0;
         iter_q   <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= {{N{1'b0}}, aMag_d};
                  mplier_q <= bMag_d;
                  neg_q    <= neg_d;
                  acc_q    <= '0;
                  iter_q   <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               if (term_d) begin
                  state_q <= FIX;
               end else begin
                  acc_q    <= accSum_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  iter_q   <= iter_q + ITW'(1);
               end
            end
            FIX: begin
               result_q <= neg_q ? -acc_q : acc_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign result_out = result_q;

endmodule
